seq_trojan_trigger: RTL and testbench
=====================================

# seq_trojan_trigger

Parametrised sequential hardware-trojan insertion block for the ISCAS-85 trojan benchmark set. It watches a group of trigger nets for a rare masked pattern, counts distinct pattern occurrences, and after a threshold applies a configurable payload to a bus of victim nets. It replaces the single-net, always-on combinational trojans, so one instance can infect any c-circuit netlist at a chosen location with a controllable activation depth for detector evaluation.

## Interface
- TRIG_W, 4: number of trigger nets observed
- VICT_W, 1: number of victim nets passed through and corrupted
- THRESH, 8: pattern occurrences needed to fire; legal range ≥1
- MODE, 0: payload type; 0 = invert (XOR), 1 = stuck-at-0, 2 = stuck-at-1
- PERSIST, 1: 1 = payload latched until reset or disarm; 0 = payload lasts PAYLOAD_CYC cycles, then re-arm
- PAYLOAD_CYC, 4: payload duration when PERSIST=0; legal range ≥1
- CNT_W, $clog2(THRESH+1): derived hit-counter width; not overridden
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arm enable; low forces IDLE
- trig_in  input  TRIG_W  observed trigger nets
- trig_val  input  TRIG_W  pattern to match
- trig_mask  input  TRIG_W  1 = bit participates in match
- victim_in  input  VICT_W  original victim net values
- victim_out  output  VICT_W  possibly corrupted victim values
- active  output  1  payload currently applied
- hit_cnt  output  CNT_W  occurrences counted since arming

## Operation
- match = &(~(trig_in ^ trig_val) | ~trig_mask); all-zero mask ⇒ match constantly 1.
- match_q: registered match; forced to 0 whenever state ≠ ARMED.
- hit = match & ~match_q: rising-edge detect, so a pattern held for many cycles counts once.
- States: IDLE, ARMED, FIRE.
- IDLE: hit_cnt=0, active=0. en=1 → ARMED.
- ARMED: each hit increments hit_cnt (saturating at THRESH). When hit occurs with hit_cnt==THRESH-1 → FIRE, hit_cnt=THRESH.
- FIRE: active=1. PERSIST=1: remain until en=0 or reset. PERSIST=0: duration counter runs PAYLOAD_CYC cycles, then → ARMED with hit_cnt=0 and match_q=0.
- en=0 in any state → IDLE next edge; counters cleared; en=0 has priority over a simultaneous threshold hit or duration expiry.
- Payload, applied only when active=1: MODE 0 victim_out = ~victim_in; MODE 1 = 0; MODE 2 = all ones. Otherwise victim_out = victim_in.
- Illegal MODE values (3) behave as MODE 0.

## Timing
- Reset (async): state IDLE, hit_cnt 0, match_q 0, duration counter 0, active 0; victim_out = victim_in immediately, including mid-FIRE.
- victim_out is combinational from victim_in and registered active: zero-latency pass-through, no added flop on the victim path.
- The hit sampled at edge k raises hit_cnt after edge k. The THRESH-th hit at edge k ⇒ active=1 after edge k.
- Transition IDLE→ARMED takes one edge. A pattern present in the first ARMED cycle counts as a hit, because match_q=0.
- PERSIST=0: active high for exactly PAYLOAD_CYC cycles. The first cycle back in ARMED may register a hit if match=1.

## Structure
- Package seq_trojan_pkg: state enum (IDLE, ARMED, FIRE) and payload-mode enum (PAY_INV, PAY_SA0, PAY_SA1).
- Sub-module trojan_payload: purely combinational, parameters VICT_W and MODE, inputs victim_in and active, output victim_out. It is reused by future combinational-trigger variants.
- Top holds the FSM, match_q, hit counter and duration counter.

## Test plan
- TRIG_W=4, mask=4'hF, val=4'hA, THRESH=3. Drive trig_in A,0,A,A,0,A with en=1 → hit_cnt 1,1,2,2,2,3; active rises after the 6th edge; VICT_W=1, victim_in=0 → victim_out=1.
- trig_in held at 4'hA for 10 cycles, THRESH=2 → hit_cnt stays 1, active stays 0.
- PERSIST=0, PAYLOAD_CYC=4, MODE=1, victim_in=1 → victim_out=0 for exactly 4 cycles; then hit_cnt=0 and active=0.
- en dropped on the same edge as the THRESH-th hit → state IDLE, active=0, hit_cnt=0.
- rst_n asserted mid-FIRE with MODE=2, victim_in=0 → victim_out=0 without waiting for a clock edge; all outputs at reset values.
- mask=0, THRESH=1 → active asserts 2 edges after en rises (IDLE→ARMED, then hit).

Source files
------------

// File: rtl/seq_trojan_trigger_pkg.sv
// Purpose: shared types for the sequential trojan trigger and its payload stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package seq_trojan_pkg;

    // Trigger FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } state_e;

    // Payload applied to the victim bus while the trojan is active.
    typedef enum logic [1:0] {
        PAY_INV = 2'd0,
        PAY_SA0 = 2'd1,
        PAY_SA1 = 2'd2
    } pay_mode_e;

    // Map a raw integer mode onto the enum; unknown codes fall back to inversion.
    function automatic pay_mode_e decode_mode(input int mode);
        case (mode)
            1:       return PAY_SA0;
            2:       return PAY_SA1;
            default: return PAY_INV;
        endcase
    endfunction

endpackage

// File: rtl/seq_trojan_trigger_payload.sv
// Purpose: corrupts the victim bus while active (invert / stuck-at-0 / stuck-at-1).
// Latency: purely combinational, zero-cycle pass-through from victim_in to victim_out.
// Backpressure: none; always accepts and drives.
// Ports: victim_in (original nets), active (payload enable), victim_out (possibly corrupted nets).
module trojan_payload
    import seq_trojan_pkg::*;
#(
    parameter int VICT_W = 1,
    parameter int MODE   = 0
) (
    input  logic [VICT_W-1:0] victim_in,
    input  logic              active,
    output logic [VICT_W-1:0] victim_out
);

    localparam pay_mode_e MODE_E = decode_mode(MODE);

    always_comb begin
        victim_out = victim_in;
        if (active) begin
            case (MODE_E)
                PAY_SA0: victim_out = '0;
                PAY_SA1: victim_out = '1;
                default: victim_out = ~victim_in;
            endcase
        end
    end

endmodule

// File: rtl/seq_trojan_trigger.sv
// Purpose: watches masked trigger nets, counts rising-edge pattern hits, fires a payload at THRESH.
// Latency: hit counted and active raised on the sampling edge; victim path is zero-latency.
// Backpressure: none; en low returns to IDLE on the next edge and overrides any hit or expiry.
// Ports: clk/rst_n, en (arm), trig_in/trig_val/trig_mask (pattern), victim_in/victim_out,
//        active (payload applied), hit_cnt (occurrences since arming).
module seq_trojan_trigger
    import seq_trojan_pkg::*;
#(
    parameter int TRIG_W      = 4,
    parameter int VICT_W      = 1,
    parameter int THRESH      = 8,
    parameter int MODE        = 0,
    parameter int PERSIST     = 1,
    parameter int PAYLOAD_CYC = 4,
    parameter int CNT_W       = $clog2(THRESH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [TRIG_W-1:0] trig_in,
    input  logic [TRIG_W-1:0] trig_val,
    input  logic [TRIG_W-1:0] trig_mask,
    input  logic [VICT_W-1:0] victim_in,
    output logic [VICT_W-1:0] victim_out,
    output logic              active,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam int DUR_W = (PAYLOAD_CYC > 1) ? $clog2(PAYLOAD_CYC) : 1;

    localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
    localparam logic [DUR_W-1:0] DUR_LAST  = DUR_W'(PAYLOAD_CYC - 1);

    state_e             state_q;
    logic               match_q;
    logic [CNT_W-1:0]   hit_cnt_q;
    logic [DUR_W-1:0]   dur_q;
    logic               active_q;

    logic               match_c;
    logic               hit_c;

    // Masked-out bits always agree, so an all-zero mask matches every cycle.
    assign match_c = &(~(trig_in ^ trig_val) | ~trig_mask);
    // Rising edge only: a pattern held for many cycles is one occurrence.
    assign hit_c   = match_c & ~match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            match_q   <= 1'b0;
            hit_cnt_q <= '0;
            dur_q     <= '0;
            active_q  <= 1'b0;
        end else if (!en) begin
            state_q   <= IDLE;
            match_q   <= 1'b0;
            hit_cnt_q <= '0;
            dur_q     <= '0;
            active_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // match_q stays clear so a pattern in the first ARMED cycle counts.
                    state_q   <= ARMED;
                    match_q   <= 1'b0;
                    hit_cnt_q <= '0;
                    dur_q     <= '0;
                    active_q  <= 1'b0;
                end
                ARMED: begin
                    match_q <= match_c;
                    if (hit_c) begin
                        if (hit_cnt_q >= THRESH_M1) begin
                            state_q   <= FIRE;
                            hit_cnt_q <= THRESH_V;
                            dur_q     <= '0;
                            active_q  <= 1'b1;
                            match_q   <= 1'b0;
                        end else begin
                            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                FIRE: begin
                    match_q <= 1'b0;
                    if (PERSIST == 0) begin
                        if (dur_q == DUR_LAST) begin
                            // Re-arm from scratch; next ARMED cycle may hit immediately.
                            state_q   <= ARMED;
                            hit_cnt_q <= '0;
                            dur_q     <= '0;
                            active_q  <= 1'b0;
                        end else begin
                            dur_q <= dur_q + DUR_W'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    match_q   <= 1'b0;
                    hit_cnt_q <= '0;
                    dur_q     <= '0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign active  = active_q;
    assign hit_cnt = hit_cnt_q;

    trojan_payload #(
        .VICT_W (VICT_W),
        .MODE   (MODE)
    ) u_payload (
        .victim_in  (victim_in),
        .active     (active_q),
        .victim_out (victim_out)
    );

endmodule

// File: tb/tb_seq_trojan_trigger.sv
// Purpose: directed self-checking bench for seq_trojan_trigger across four parameterisations.
// Latency: inputs driven 1ns after posedge, outputs checked at the same point (after the edge).
// Backpressure: n/a.
module tb_seq_trojan_trigger;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] trig_in;
    logic [3:0] trig_val;
    logic [3:0] trig_mask;
    logic [0:0] victim_in;

    logic [0:0] vo_a, vo_b, vo_c, vo_d;
    logic       act_a, act_b, act_c, act_d;
    logic [1:0] hc_a, hc_b, hc_c;
    logic [0:0] hc_d;

    int checks = 0;
    int errors = 0;

    // A: THRESH=3, invert, persistent
    seq_trojan_trigger #(.TRIG_W(4), .VICT_W(1), .THRESH(3), .MODE(0), .PERSIST(1), .PAYLOAD_CYC(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .trig_in(trig_in), .trig_val(trig_val),
        .trig_mask(trig_mask), .victim_in(victim_in), .victim_out(vo_a), .active(act_a), .hit_cnt(hc_a));

    // B: THRESH=2, held-pattern check
    seq_trojan_trigger #(.TRIG_W(4), .VICT_W(1), .THRESH(2), .MODE(0), .PERSIST(1), .PAYLOAD_CYC(4)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .trig_in(trig_in), .trig_val(trig_val),
        .trig_mask(trig_mask), .victim_in(victim_in), .victim_out(vo_b), .active(act_b), .hit_cnt(hc_b));

    // C: THRESH=2, stuck-at-0, timed payload of 4 cycles
    seq_trojan_trigger #(.TRIG_W(4), .VICT_W(1), .THRESH(2), .MODE(1), .PERSIST(0), .PAYLOAD_CYC(4)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .trig_in(trig_in), .trig_val(trig_val),
        .trig_mask(trig_mask), .victim_in(victim_in), .victim_out(vo_c), .active(act_c), .hit_cnt(hc_c));

    // D: THRESH=1, stuck-at-1, persistent
    seq_trojan_trigger #(.TRIG_W(4), .VICT_W(1), .THRESH(1), .MODE(2), .PERSIST(1), .PAYLOAD_CYC(4)) u_d (
        .clk(clk), .rst_n(rst_n), .en(en), .trig_in(trig_in), .trig_val(trig_val),
        .trig_mask(trig_mask), .victim_in(victim_in), .victim_out(vo_d), .active(act_d), .hit_cnt(hc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] pat  [6];
    logic [1:0] expc [6];

    initial begin
        pat  = '{4'hA, 4'h0, 4'hA, 4'hA, 4'h0, 4'hA};
        expc = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

        rst_n     = 1'b1;
        en        = 1'b0;
        trig_in   = 4'h0;
        trig_val  = 4'hA;
        trig_mask = 4'hF;
        victim_in = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_hit_cnt", 32'(hc_a), 32'd0);
        chk("rst_active", 32'(act_a), 32'd0);
        chk("rst_victim", 32'(vo_a), 32'd0);
        chk("rst_active_d", 32'(act_d), 32'd0);
        #9 rst_n = 1'b1;
        step();

        // Hit sequence A,0,A,A,0,A with THRESH=3
        en = 1'b1;
        step();
        chk("arm_cnt", 32'(hc_a), 32'd0);
        for (int i = 0; i < 6; i++) begin
            trig_in = pat[i];
            step();
            chk($sformatf("seq_cnt%0d", i), 32'(hc_a), 32'(expc[i]));
            chk($sformatf("seq_act%0d", i), 32'(act_a), (i == 5) ? 32'd1 : 32'd0);
        end
        chk("seq_victim_inv", 32'(vo_a), 32'd1);
        // Persistent: further hits change nothing
        trig_in = 4'h0;
        step();
        trig_in = 4'hA;
        step();
        step();
        chk("persist_act", 32'(act_a), 32'd1);
        chk("persist_cnt", 32'(hc_a), 32'd3);
        en = 1'b0;
        step();
        chk("disarm_act", 32'(act_a), 32'd0);
        chk("disarm_cnt", 32'(hc_a), 32'd0);
        chk("disarm_victim", 32'(vo_a), 32'd0);

        // Held pattern counts once (THRESH=2)
        trig_in = 4'h0;
        en = 1'b1;
        step();
        trig_in = 4'hA;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("hold_cnt%0d", i), 32'(hc_b), 32'd1);
        end
        chk("hold_act", 32'(act_b), 32'd0);

        // Timed stuck-at-0 payload for 4 cycles, then re-arm
        en = 1'b0;
        step();
        victim_in = 1'b1;
        trig_in = 4'h0;
        en = 1'b1;
        step();
        trig_in = 4'hA;
        step();
        trig_in = 4'h0;
        step();
        trig_in = 4'hA;
        step();
        chk("tmr_act0", 32'(act_c), 32'd1);
        chk("tmr_vo0", 32'(vo_c), 32'd0);
        chk("tmr_cnt0", 32'(hc_c), 32'd2);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("tmr_vo%0d", i), 32'(vo_c), 32'd0);
        end
        step();
        chk("tmr_end_act", 32'(act_c), 32'd0);
        chk("tmr_end_cnt", 32'(hc_c), 32'd0);
        chk("tmr_end_vo", 32'(vo_c), 32'd1);
        step();
        chk("rearm_hit", 32'(hc_c), 32'd1);

        // en dropped on the same edge as the third hit
        en = 1'b0;
        victim_in = 1'b0;
        trig_in = 4'h0;
        step();
        en = 1'b1;
        step();
        trig_in = 4'hA;
        step();
        trig_in = 4'h0;
        step();
        trig_in = 4'hA;
        step();
        trig_in = 4'h0;
        step();
        chk("race_pre_cnt", 32'(hc_a), 32'd2);
        trig_in = 4'hA;
        en = 1'b0;
        step();
        chk("race_act", 32'(act_a), 32'd0);
        chk("race_cnt", 32'(hc_a), 32'd0);

        // All-zero mask, THRESH=1: fires two edges after en rises
        trig_mask = 4'h0;
        step();
        en = 1'b1;
        step();
        chk("mask0_edge1_act", 32'(act_d), 32'd0);
        chk("mask0_edge1_cnt", 32'(hc_d), 32'd0);
        step();
        chk("mask0_edge2_act", 32'(act_d), 32'd1);
        chk("mask0_edge2_cnt", 32'(hc_d), 32'd1);
        chk("mask0_sa1_vo", 32'(vo_d), 32'd1);

        // Async reset mid-FIRE, checked before the next clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("arst_vo", 32'(vo_d), 32'd0);
        chk("arst_act", 32'(act_d), 32'd0);
        chk("arst_cnt", 32'(hc_d), 32'd0);
        #2 rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
